mem_port_arbiter: RTL and testbench

- Shares the single CPU memory port between instruction fetch (IF) and the data path (SW store / load).
- Runs a 3-state FSM that serialises accesses and alternates grants round-robin.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Guards against a hung memory with a timeout; sits between the core (fetch unit, control-driven mem_we) and memory.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_rr_arb2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared constants for the CPU memory-port arbiter.
//   - FSM state encodings (binary, 2 bits)
//   - grant identifiers (IF = fetch, D = data path)
//   - default address/data widths
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  // gnt vector bit index doubles as the grant id: bit 0 = IF, bit 1 = D
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   req[1:0]   - request vector (bit 0 = IF, bit 1 = D)
//   last_grant - id of the previous winner
//   gnt[1:0]   - one-hot grant, zero when nothing is requested
// On contention the requester that did not win last time is picked.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == GRANT_IF) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single CPU memory port between instruction
// fetch (IF) and the data path (loads/stores). IDLE -> ACCESS -> ACK FSM,
// round-robin on contention, one-cycle ack, sticky timeout on a hung memory.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   if_req/if_addr          fetch request; if_rdata/if_ack response
//   d_req/d_we/d_addr/
//   d_wdata                 data request; d_rdata/d_ack response
//   mem_valid/mem_we/
//   mem_addr/mem_wdata      memory request (registered, stable in ACCESS)
//   mem_ready/mem_rdata     memory completion
//   busy                    FSM not in IDLE
//   timeout_err             sticky, cleared only by reset
//
// Optional build macro ARB_STATS_EN adds 16-bit saturating grant counters
// if_grant_cnt / d_grant_cnt.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef ARB_STATS_EN
  output logic [15:0]       if_grant_cnt,
  output logic [15:0]       d_grant_cnt,
`endif
  output logic              busy,
  output logic              timeout_err
);

  // Abort when the cycle that would make the wait count reach TIMEOUT
  // still has no mem_ready, i.e. after exactly TIMEOUT ACCESS cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state;
  logic              last_grant;
  logic              cur_grant;
  logic [7:0]        tmo_cnt;
  logic [1:0]        gnt;
  logic              done;
  logic [DATA_W-1:0] rd_val;

  rr_arb2 u_rr (
    .req        ({d_req, if_req}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign busy = (state != ST_IDLE);
  assign done = mem_ready || (tmo_cnt == TMO_LAST);

  // Writes and aborted accesses return zero
  always_comb begin
    rd_val = '0;
    if (mem_ready && !mem_we) rd_val = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= GRANT_IF;
      cur_grant   <= GRANT_IF;
      tmo_cnt     <= '0;
      mem_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            cur_grant  <= gnt[1] ? GRANT_D : GRANT_IF;
            last_grant <= gnt[1] ? GRANT_D : GRANT_IF;
            mem_valid  <= 1'b1;
            mem_we     <= gnt[1] & d_we;
            mem_addr   <= gnt[1] ? d_addr : if_addr;
            mem_wdata  <= gnt[1] ? d_wdata : '0;
            tmo_cnt    <= '0;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (done) begin
            if (cur_grant == GRANT_D) begin
              d_rdata <= rd_val;
              d_ack   <= 1'b1;
            end else begin
              if_rdata <= rd_val;
              if_ack   <= 1'b1;
            end
            if (!mem_ready) timeout_err <= 1'b1;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            state     <= ST_ACK;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_ACK: begin
          tmo_cnt <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_grant_cnt <= '0;
      d_grant_cnt  <= '0;
    end else if (state == ST_IDLE) begin
      if (gnt[0] && if_grant_cnt != 16'hFFFF) if_grant_cnt <= if_grant_cnt + 16'd1;
      if (gnt[1] && d_grant_cnt  != 16'hFFFF) d_grant_cnt  <= d_grant_cnt  + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
// (built with TIMEOUT=4). Inputs are driven and outputs sampled on the
// falling edge; the DUT acts on the rising edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        timeout_err;
`ifdef ARB_STATS_EN
  logic [15:0] if_grant_cnt;
  logic [15:0] d_grant_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ack      (if_ack),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ack       (d_ack),
    .mem_valid   (mem_valid),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
`ifdef ARB_STATS_EN
    .if_grant_cnt(if_grant_cnt),
    .d_grant_cnt (d_grant_cnt),
`endif
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // single requester, zero-wait read; checks the ack lands two cycles later
  task automatic do_acc(input bit use_d);
    if_req = ~use_d; d_req = use_d; d_we = 1'b0; mem_ready = 1'b1;
    tick();
    tick();
    check(use_d ? "stat_d_ack" : "stat_if_ack", use_d ? d_ack : if_ack, 1);
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    @(negedge clk);
    tick();

    // reset state
    check("rst_mem_valid", mem_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_acks", {if_ack, d_ack}, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_rdata", if_rdata | d_rdata, 0);
`ifdef ARB_STATS_EN
    check("rst_cnts", {if_grant_cnt, d_grant_cnt}, 0);
`endif
    rst_n = 1'b1;
    tick();

    // 1: IF only, ready in first ACCESS cycle
    if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    check("t1_valid", mem_valid, 1);
    check("t1_addr", mem_addr, 32'h10);
    check("t1_we", mem_we, 0);
    check("t1_early_ack", if_ack, 0);
    tick();
    check("t1_if_ack", if_ack, 1);
    check("t1_rdata", if_rdata, 32'hDEADBEEF);
    check("t1_d_ack", d_ack, 0);
    check("t1_valid_off", mem_valid, 0);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("t1_ack_pulse", if_ack, 0);
    check("t1_idle", busy, 0);

    // 2: data store, 3 wait cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t2_we", mem_we, 1);
      check("t2_addr", mem_addr, 32'h40);
      check("t2_wdata", mem_wdata, 32'h12345678);
      check("t2_no_ack", d_ack, 0);
      if (k == 3) mem_ready = 1'b1;
      tick();
    end
    check("t2_d_ack", d_ack, 1);
    check("t2_d_rdata", d_rdata, 0);
    check("t2_busy_ack", busy, 1);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    tick();
    check("t2_ack_pulse", d_ack, 0);
    check("t2_busy_fall", busy, 0);

    // 3: contention from reset, zero-wait memory: D, IF, D, IF
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_addr", mem_addr, (i % 2 == 0) ? 32'h200 : 32'h100);
      mem_rdata = 32'h1000 + i;
      tick();
      check("t3_d_ack", d_ack, (i % 2 == 0) ? 1 : 0);
      check("t3_if_ack", if_ack, (i % 2 == 0) ? 0 : 1);
      check("t3_rdata", (i % 2 == 0) ? d_rdata : if_rdata, 32'h1000 + i);
      tick();
      check("t3_idle", busy, 0);
    end
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;

    // 4: timeout on IF read (TIMEOUT=4)
    if_req = 1'b1; if_addr = 32'h20;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t4_valid", mem_valid, 1);
      check("t4_tmo_pre", timeout_err, 0);
      tick();
    end
    check("t4_valid_off", mem_valid, 0);
    check("t4_if_ack", if_ack, 1);
    check("t4_rdata", if_rdata, 0);
    check("t4_tmo", timeout_err, 1);
    if_req = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
    tick();
    tick();
    check("t4_good_ack", d_ack, 1);
    check("t4_good_rdata", d_rdata, 32'hCAFE0001);
    check("t4_tmo_sticky", timeout_err, 1);
    d_req = 1'b0; mem_ready = 1'b0;
    tick();

    // 5: reset during ACCESS
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h55;
    tick();
    check("t5_valid", mem_valid, 1);
    rst_n = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();
    check("t5_valid_rst", mem_valid, 0);
    check("t5_busy_rst", busy, 0);
    check("t5_tmo_rst", timeout_err, 0);
    check("t5_acks_rst", {if_ack, d_ack}, 0);
    rst_n = 1'b1;
    tick();
    check("t5_no_ack", {if_ack, d_ack}, 0);
    if_req = 1'b1; if_addr = 32'h90; d_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h77;
    tick();
    check("t5_first_gnt_d", mem_addr, 32'h80);
    if_req = 1'b0; d_req = 1'b0;
    tick();
    check("t5_d_ack", d_ack, 1);
    mem_ready = 1'b0;
    tick();

`ifdef ARB_STATS_EN
    // 6: grant counters
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_cnt_rst", {if_grant_cnt, d_grant_cnt}, 0);
    do_acc(1'b0); do_acc(1'b1); do_acc(1'b0); do_acc(1'b1); do_acc(1'b0);
    check("t6_if_cnt", {16'd0, if_grant_cnt}, 3);
    check("t6_d_cnt", {16'd0, d_grant_cnt}, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_cnt_rst2", {if_grant_cnt, d_grant_cnt}, 0);
`else
    do_acc(1'b0);
    do_acc(1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
